// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/result handshake bundle of the bit-serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;

  modport master (
    output start, input1, input2,
    input  ready, done, difference, borrow
  );

  modport slave (
    input  start, input1, input2,
    output ready, done, difference, borrow
  );

endinterface

// File: rtl/fullsubtractor_bit.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module fullsubtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of a single column
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: input1 - input2, LSB first, one bit per clock.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_state == BUSY) && (r_cnt == LAST_BIT);

  fullsubtractor_bit u_bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB;
  // written as shifts so WIDTH=1 needs no special case.
  assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start outside IDLE is simply dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:                   w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.ready = (r_state == IDLE);
    bus.done  = (r_state == DONE);
  end

  // Bit counter, borrow flop and published result; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_bin <= 1'b0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 1'b1;
      r_bin <= w_bout;
      if (w_last) begin
        r_diff   <= w_res_nxt;
        r_borrow <= w_bout;
      end
    end
  end

  // Operand and result shift registers; contents are don't-care outside BUSY
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a   <= bus.input1;
      r_b   <= bus.input2;
      r_res <= '0;
    end else if (r_state == BUSY) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_nxt;
    end
  end

  assign bus.difference = r_diff;
  assign bus.borrow     = r_borrow;

endmodule
